// File: rtl/dda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dda_pkg
// Description : Shared types, default sizing and the saturation helper for
//               the multi-channel DDA integrator array.
// Revision    : 1.0 - initial release
// ============================================================================
package dda_pkg;

   // Step sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROD = 2'd1,
      UPD  = 2'd2,
      DONE = 2'd3
   } fsm_state_e;

   // Default configuration of the array
   localparam int DEF_DATA_WIDTH     = 16;
   localparam int DEF_TIME_WIDTH     = 16;
   localparam int DEF_TIME_SCALE_POW = 8;
   localparam int DEF_NUM_CH         = 4;

   // Remainder width and full product width for the default configuration
   localparam int S             = DEF_TIME_SCALE_POW + 1;
   localparam int PRODUCT_WIDTH = DEF_TIME_WIDTH + DEF_DATA_WIDTH + 2;

   // Working width of the saturation helper; every caller sign-extends into it
   localparam int SAT_W = 64;

   // Clamp a signed value into the signed range of 'width' bits.
   // The result stays SAT_W wide so the caller can compare it with the
   // input to detect that a clamp happened.
   function automatic logic signed [SAT_W-1:0] sat_to_width(
      input logic signed [SAT_W-1:0] val,
      input int                      width
   );
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = ~max_v;
      if (val > max_v) begin
         return max_v;
      end else if (val < min_v) begin
         return min_v;
      end else begin
         return val;
      end
   endfunction

endpackage : dda_pkg
`default_nettype wire

// File: rtl/dda_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : dda_mac_lane
// Description : Shared combinational datapath: operand select, dt*op + r,
//               floor shift, remainder split and dz saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module dda_mac_lane
   import dda_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIME_WIDTH     = DEF_TIME_WIDTH,
   parameter int TIME_SCALE_POW = DEF_TIME_SCALE_POW
) (
   input  logic                      mode,
   input  logic [TIME_WIDTH-1:0]     dt,
   input  logic [DATA_WIDTH-1:0]     y_cur,
   input  logic [DATA_WIDTH-1:0]     y_old,
   input  logic [TIME_SCALE_POW:0]   rem_in,
   output logic [DATA_WIDTH-1:0]     dz,
   output logic [TIME_SCALE_POW:0]   rem_out,
   output logic                      dz_sat
);

   localparam int SW  = TIME_SCALE_POW + 1;
   localparam int PW  = TIME_WIDTH + DATA_WIDTH + 2;
   localparam int OPW = DATA_WIDTH + 1;

   logic signed [OPW-1:0]   w_op;
   logic signed [PW-1:0]    w_dt_ext;
   logic signed [PW-1:0]    w_op_ext;
   logic signed [PW-1:0]    w_rem_ext;
   logic signed [PW-1:0]    w_p;
   logic signed [PW-1:0]    w_q;
   logic signed [SAT_W-1:0] w_q_ext;
   logic signed [SAT_W-1:0] w_q_sat;

   // Operand: 2*y for Euler, y + y_prev for trapezoidal; both share the dt scale
   always_comb begin
      w_op = '0;
      if (mode) begin
         w_op = {y_cur[DATA_WIDTH-1], y_cur} + {y_old[DATA_WIDTH-1], y_old};
      end else begin
         w_op = {y_cur, 1'b0};
      end
   end

   // Full-width multiply-add; the product always fits so no bits are lost
   assign w_dt_ext  = {{(PW-TIME_WIDTH){dt[TIME_WIDTH-1]}}, dt};
   assign w_op_ext  = {{(PW-OPW){w_op[OPW-1]}}, w_op};
   assign w_rem_ext = {{(PW-SW){1'b0}}, rem_in};
   assign w_p       = w_rem_ext + (w_dt_ext * w_op_ext);

   // Arithmetic shift floors toward -inf, leaving a non-negative remainder
   assign w_q     = w_p >>> SW;
   assign rem_out = w_p[SW-1:0];

   assign w_q_ext = {{(SAT_W-PW){w_q[PW-1]}}, w_q};
   assign w_q_sat = sat_to_width(w_q_ext, DATA_WIDTH);
   assign dz      = w_q_sat[DATA_WIDTH-1:0];
   assign dz_sat  = (w_q_sat != w_q_ext);

endmodule : dda_mac_lane
`default_nettype wire

// File: rtl/dda_integrator_array.sv
`default_nettype none
// ============================================================================
// Module      : dda_integrator_array
// Description : NUM_CH-channel DDA integrator. One shared MAC lane is swept
//               over the channels, then all states update in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module dda_integrator_array
   import dda_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIME_WIDTH     = DEF_TIME_WIDTH,
   parameter int TIME_SCALE_POW = DEF_TIME_SCALE_POW,
   parameter int NUM_CH         = DEF_NUM_CH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             step_valid,
   output logic                             step_ready,
   input  logic                             mode,
   input  logic [TIME_WIDTH-1:0]            dt,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     dy,
   input  logic [NUM_CH-1:0]                load_mask,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     y0,
   output logic                             out_valid,
   output logic [NUM_CH*DATA_WIDTH-1:0]     dz,
   output logic [NUM_CH*DATA_WIDTH-1:0]     y,
   output logic [NUM_CH-1:0]                sat_flags
);

   localparam int SW    = TIME_SCALE_POW + 1;
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   fsm_state_e              r_state;
   fsm_state_e              w_next_state;
   logic                    w_accept;
   logic                    w_prod_en;
   logic                    w_upd_en;

   logic [IDX_W-1:0]        r_ch_idx;
   logic                    r_mode;
   logic [TIME_WIDTH-1:0]   r_dt;
   logic [NUM_CH-1:0]       r_load_mask;
   logic [DATA_WIDTH-1:0]   r_dy      [NUM_CH];
   logic [DATA_WIDTH-1:0]   r_y0      [NUM_CH];

   logic [DATA_WIDTH-1:0]   r_y       [NUM_CH];
   logic [DATA_WIDTH-1:0]   r_y_prev  [NUM_CH];
   logic [DATA_WIDTH-1:0]   r_dz      [NUM_CH];
   logic [SW-1:0]           r_rem     [NUM_CH];
   logic [NUM_CH-1:0]       r_sat;

   logic [DATA_WIDTH-1:0]   w_lane_dz;
   logic [SW-1:0]           w_lane_rem;
   logic                    w_lane_sat;

   logic [DATA_WIDTH-1:0]   w_y_next  [NUM_CH];
   logic [NUM_CH-1:0]       w_y_sat;

   assign w_accept = step_valid && step_ready;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: sweep channels, then one update cycle, then report
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = PROD;
         PROD:    if (r_ch_idx == LAST_IDX) w_next_state = UPD;
         UPD:     w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State-decoded controls and handshake outputs
   always_comb begin
      step_ready = (r_state == IDLE);
      out_valid  = (r_state == DONE);
      w_prod_en  = (r_state == PROD);
      w_upd_en   = (r_state == UPD);
   end

   // Capture the step request so the inputs may change while busy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode      <= 1'b0;
         r_dt        <= '0;
         r_load_mask <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_dy[k] <= '0;
            r_y0[k] <= '0;
         end
      end else if (w_accept) begin
         r_mode      <= mode;
         r_dt        <= dt;
         r_load_mask <= load_mask;
         for (int k = 0; k < NUM_CH; k++) begin
            r_dy[k] <= dy[k*DATA_WIDTH +: DATA_WIDTH];
            r_y0[k] <= y0[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Channel pointer for the shared lane, restarted on every accepted step
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ch_idx <= '0;
      end else if (w_accept) begin
         r_ch_idx <= '0;
      end else if (w_prod_en && (r_ch_idx != LAST_IDX)) begin
         r_ch_idx <= r_ch_idx + 1'b1;
      end
   end

   dda_mac_lane #(
      .DATA_WIDTH     (DATA_WIDTH),
      .TIME_WIDTH     (TIME_WIDTH),
      .TIME_SCALE_POW (TIME_SCALE_POW)
   ) u_lane (
      .mode    (r_mode),
      .dt      (r_dt),
      .y_cur   (r_y[r_ch_idx]),
      .y_old   (r_y_prev[r_ch_idx]),
      .rem_in  (r_rem[r_ch_idx]),
      .dz      (w_lane_dz),
      .rem_out (w_lane_rem),
      .dz_sat  (w_lane_sat)
   );

   // Saturating y + dy per channel, evaluated in parallel for the update cycle
   for (genvar k = 0; k < NUM_CH; k++) begin : g_y_next
      logic [DATA_WIDTH:0]     w_sum;
      logic signed [SAT_W-1:0] w_sum_ext;
      logic signed [SAT_W-1:0] w_sum_sat;

      assign w_sum       = {r_y[k][DATA_WIDTH-1], r_y[k]} + {r_dy[k][DATA_WIDTH-1], r_dy[k]};
      assign w_sum_ext   = {{(SAT_W-DATA_WIDTH-1){w_sum[DATA_WIDTH]}}, w_sum};
      assign w_sum_sat   = sat_to_width(w_sum_ext, DATA_WIDTH);
      assign w_y_next[k] = w_sum_sat[DATA_WIDTH-1:0];
      assign w_y_sat[k]  = (w_sum_sat != w_sum_ext);
   end

   // Channel state: dz/r written per channel in PROD, y/y_prev all at once in UPD.
   // A load in UPD clears r and the flag, overriding anything PROD just wrote.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sat <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_y[k]      <= '0;
            r_y_prev[k] <= '0;
            r_dz[k]     <= '0;
            r_rem[k]    <= '0;
         end
      end else begin
         if (w_prod_en) begin
            r_dz[r_ch_idx]  <= w_lane_dz;
            r_rem[r_ch_idx] <= w_lane_rem;
            if (w_lane_sat) begin
               r_sat[r_ch_idx] <= 1'b1;
            end
         end
         if (w_upd_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (r_load_mask[k]) begin
                  r_y[k]      <= r_y0[k];
                  r_y_prev[k] <= r_y0[k];
                  r_rem[k]    <= '0;
                  r_sat[k]    <= 1'b0;
               end else begin
                  r_y_prev[k] <= r_y[k];
                  r_y[k]      <= w_y_next[k];
                  if (w_y_sat[k]) begin
                     r_sat[k] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   // Flatten per-channel state onto the packed output buses
   for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
      assign dz[k*DATA_WIDTH +: DATA_WIDTH] = r_dz[k];
      assign y[k*DATA_WIDTH +: DATA_WIDTH]  = r_y[k];
   end

   assign sat_flags = r_sat;

endmodule : dda_integrator_array
`default_nettype wire
